// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine
// Sequences a DXYN-style sprite draw into a 128x64, 2-bit-per-pixel VRAM.
// Each sprite byte is fetched from RAM. Each set, unclipped pixel is then read
// from VRAM, XORed with the plane mask and written back. The collision flag
// (VF) is raised when any written pixel already had a bit in the plane mask.
module sprite_draw_engine #(
  // 1: pixels past the right/bottom edge are dropped; 0: they wrap around
  parameter bit CLIP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  input  logic [1:0]  plane,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  output logic [1:0]  vram_pixeli,
  input  logic [1:0]  vram_pixelo,
  output logic        vram_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_PIX,
    S_PIX_WAIT,
    S_PIX_WRITE,
    S_DONE
  } state_t;

  state_t      state_q;

  // Draw parameters captured when a start is accepted
  logic [6:0]  x_q;
  logic [5:0]  y_q;
  logic [3:0]  n_q;
  logic [11:0] base_q;
  logic [1:0]  plane_q;

  // Traversal position: byte index into the sprite and bit index within it
  logic [4:0]  byte_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        draw_q;   // pixel at bit_q needs a read-XOR-write
  logic [1:0]  pix_q;    // VRAM value read back for the current pixel

  // Registered outputs
  logic        busy_q;
  logic        done_q;
  logic        coll_q;
  logic [11:0] ram_addr_q;
  logic [6:0]  hpos_q;
  logic [5:0]  vpos_q;
  logic [1:0]  pixeli_q;
  logic        we_q;

  // Sprite geometry derived from the latched row count
  logic        wide;
  logic [4:0]  last_byte;
  logic [3:0]  row;
  logic [3:0]  col_base;
  logic [11:0] next_addr;

  assign wide      = (n_q == 4'd0);
  assign last_byte = wide ? 5'd31 : ({1'b0, n_q} - 5'd1);
  assign row       = wide ? byte_q[4:1] : byte_q[3:0];
  assign col_base  = (wide && byte_q[0]) ? 4'd8 : 4'd0;
  // Byte k of either sprite shape lives at base + k; the sum wraps mod 4096
  assign next_addr = base_q + {7'd0, byte_q + 5'd1};

  // Look-ahead for the pixel about to be entered in PIX, so that hpos/vpos are
  // already registered and valid while the PIX cycle issues the VRAM read
  logic [2:0]  la_bit;
  logic [7:0]  la_data;
  logic [3:0]  la_col;
  logic [7:0]  la_ux;
  logic [6:0]  la_uy;
  logic        la_clip;
  logic        draw_d;
  logic [6:0]  hpos_d;
  logic [5:0]  vpos_d;

  // Decide whether the next pixel is set and on-screen, and where it lands
  always_comb begin
    la_bit  = (state_q == S_FETCH_WAIT) ? 3'd7 : (bit_q - 3'd1);
    la_data = (state_q == S_FETCH_WAIT) ? ram_dout : sh_q;
    la_col  = col_base + {1'b0, 3'd7 - la_bit};
    la_ux   = {1'b0, x_q} + {4'd0, la_col};
    la_uy   = {1'b0, y_q} + {3'd0, row};
    la_clip = CLIP && (la_ux[7] || la_uy[6]);
    draw_d  = la_data[la_bit] && !la_clip;
    hpos_d  = la_ux[6:0];
    vpos_d  = la_uy[5:0];
  end

  // Draw sequencer: state, traversal counters and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= 7'd0;
      y_q        <= 6'd0;
      n_q        <= 4'd0;
      base_q     <= 12'd0;
      plane_q    <= 2'd0;
      byte_q     <= 5'd0;
      bit_q      <= 3'd0;
      sh_q       <= 8'd0;
      draw_q     <= 1'b0;
      pix_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      ram_addr_q <= 12'd0;
      hpos_q     <= 7'd0;
      vpos_q     <= 6'd0;
      pixeli_q   <= 2'd0;
      we_q       <= 1'b0;
    end else begin
      // Write enable and done are single-cycle strobes
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q        <= x;
            y_q        <= y;
            n_q        <= n;
            base_q     <= i_addr;
            plane_q    <= plane;
            byte_q     <= 5'd0;
            coll_q     <= 1'b0;
            busy_q     <= 1'b1;
            ram_addr_q <= i_addr;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // ram_addr is presented during this cycle; data arrives next cycle
          state_q <= S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          sh_q   <= ram_dout;
          bit_q  <= 3'd7;
          draw_q <= draw_d;
          if (draw_d) begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
          end
          state_q <= S_PIX;
        end
        S_PIX, S_PIX_WRITE: begin
          if (state_q == S_PIX && draw_q) begin
            // hpos/vpos are presented during this cycle for the VRAM read
            state_q <= S_PIX_WAIT;
          end else begin
            if (state_q == S_PIX_WRITE && (pix_q & plane_q) != 2'b00) begin
              coll_q <= 1'b1;
            end
            if (bit_q != 3'd0) begin
              bit_q  <= bit_q - 3'd1;
              draw_q <= draw_d;
              if (draw_d) begin
                hpos_q <= hpos_d;
                vpos_q <= vpos_d;
              end
              state_q <= S_PIX;
            end else if (byte_q == last_byte) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              byte_q     <= byte_q + 5'd1;
              ram_addr_q <= next_addr;
              state_q    <= S_FETCH;
            end
          end
        end
        S_PIX_WAIT: begin
          pix_q    <= vram_pixelo;
          pixeli_q <= vram_pixelo ^ plane_q;
          we_q     <= 1'b1;
          state_q  <= S_PIX_WRITE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign collision   = coll_q;
  assign ram_addr    = ram_addr_q;
  assign vram_hpos   = hpos_q;
  assign vram_vpos   = vpos_q;
  assign vram_pixeli = pixeli_q;
  assign vram_we     = we_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Testbench for sprite_draw_engine: a clipping (CLIP=1) and a wrapping (CLIP=0)
// instance share stimulus, each with its own RAM read port and VRAM model.
// Expected results come from a pixel-by-pixel sprite model on a shadow VRAM.
module tb_sprite_draw_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        clr;
  logic [6:0]  x_r;
  logic [5:0]  y_r;
  logic [3:0]  n_r;
  logic [11:0] ia_r;
  logic [1:0]  pl_r;

  logic        busy_w [2];
  logic        done_w [2];
  logic        coll_w [2];
  logic        we_w   [2];
  logic [11:0] ram_addr_w [2];
  logic [7:0]  ram_dout_w [2];
  logic [6:0]  hpos_w [2];
  logic [5:0]  vpos_w [2];
  logic [1:0]  pixi_w [2];
  logic [1:0]  pixo_w [2];

  logic [7:0]  ram  [0:4095];
  logic [1:0]  vv   [0:1][0:63][0:127];
  logic [1:0]  expv [0:1][0:63][0:127];

  int cyc_tot  [2] = '{0, 0};
  int wr_tot   [2] = '{0, 0};
  int done_tot [2] = '{0, 0};
  int stray_we [2] = '{0, 0};

  int vectors     = 0;
  int miscompares = 0;

  int obs_cyc [2];
  int obs_wr  [2];

  sprite_draw_engine #(.CLIP(1'b1)) dut_clip (
    .clk(clk), .reset(reset), .start(start),
    .x(x_r), .y(y_r), .n(n_r), .i_addr(ia_r), .plane(pl_r),
    .busy(busy_w[0]), .done(done_w[0]), .collision(coll_w[0]),
    .ram_addr(ram_addr_w[0]), .ram_dout(ram_dout_w[0]),
    .vram_hpos(hpos_w[0]), .vram_vpos(vpos_w[0]),
    .vram_pixeli(pixi_w[0]), .vram_pixelo(pixo_w[0]), .vram_we(we_w[0])
  );

  sprite_draw_engine #(.CLIP(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start),
    .x(x_r), .y(y_r), .n(n_r), .i_addr(ia_r), .plane(pl_r),
    .busy(busy_w[1]), .done(done_w[1]), .collision(coll_w[1]),
    .ram_addr(ram_addr_w[1]), .ram_dout(ram_dout_w[1]),
    .vram_hpos(hpos_w[1]), .vram_vpos(vpos_w[1]),
    .vram_pixeli(pixi_w[1]), .vram_pixelo(pixo_w[1]), .vram_we(we_w[1])
  );

  // Synchronous-read RAM and VRAM models plus activity counters
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ram_dout_w[k] <= ram[ram_addr_w[k]];
      pixo_w[k]     <= vv[k][vpos_w[k]][hpos_w[k]];
      if (clr) begin
        for (int r = 0; r < 64; r++)
          for (int c = 0; c < 128; c++)
            vv[k][r][c] <= 2'b00;
      end else if (we_w[k]) begin
        vv[k][vpos_w[k]][hpos_w[k]] <= pixi_w[k];
      end
      if (busy_w[k]) cyc_tot[k] <= cyc_tot[k] + 1;
      if (we_w[k]) wr_tot[k] <= wr_tot[k] + 1;
      if (done_w[k]) done_tot[k] <= done_tot[k] + 1;
      if (we_w[k] && !busy_w[k]) stray_we[k] <= stray_we[k] + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Sprite model: walks rows/columns, applies clipping or wrapping, XORs the
  // shadow VRAM and derives writes, collision and the busy-cycle cost.
  task automatic model(input int k, input logic [6:0] xx, input logic [5:0] yy,
                       input logic [3:0] nn, input logic [11:0] ia, input logic [1:0] pl,
                       output int cyc, output int wr, output int coll);
    int rows, w, nbytes, ux, uy;
    logic [7:0]  b;
    logic [11:0] a;
    rows   = (nn == 4'd0) ? 16 : int'(nn);
    w      = (nn == 4'd0) ? 16 : 8;
    nbytes = rows * w / 8;
    wr     = 0;
    coll   = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < w; c++) begin
        a = ia + 12'((w == 16) ? (2 * r + c / 8) : r);
        b = ram[a];
        if (b[7 - (c % 8)]) begin
          ux = int'(xx) + c;
          uy = int'(yy) + r;
          if (!(k == 0 && (ux > 127 || uy > 63))) begin
            if ((expv[k][uy % 64][ux % 128] & pl) != 2'b00) coll = 1;
            expv[k][uy % 64][ux % 128] = expv[k][uy % 64][ux % 128] ^ pl;
            wr++;
          end
        end
      end
    end
    cyc = 2 * nbytes + 3 * wr + (8 * nbytes - wr) + 1;
  endtask

  function automatic int vdiff(input int k);
    int d = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++)
        if (vv[k][r][c] !== expv[k][r][c]) d++;
    return d;
  endfunction

  task automatic do_draw(input string tag, input logic [6:0] xx, input logic [5:0] yy,
                         input logic [3:0] nn, input logic [11:0] ia, input logic [1:0] pl,
                         input bit mid_start);
    int ecyc [2];
    int ewr  [2];
    int ecol [2];
    int c0 [2];
    int w0 [2];
    int d0 [2];
    int guard;
    for (int k = 0; k < 2; k++) begin
      model(k, xx, yy, nn, ia, pl, ecyc[k], ewr[k], ecol[k]);
      c0[k] = cyc_tot[k];
      w0[k] = wr_tot[k];
      d0[k] = done_tot[k];
    end
    @(negedge clk);
    x_r = xx; y_r = yy; n_r = nn; ia_r = ia; pl_r = pl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s busy after start", tag), int'(busy_w[0] & busy_w[1]), 1);
    if (mid_start) begin
      repeat (3) @(negedge clk);
      x_r = ~xx; y_r = ~yy; n_r = nn + 4'd3; ia_r = ~ia; pl_r = ~pl; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while ((busy_w[0] || busy_w[1]) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("%s completes in bound", tag), int'(guard < 5000), 1);
    for (int k = 0; k < 2; k++) begin
      obs_cyc[k] = cyc_tot[k] - c0[k];
      obs_wr[k]  = wr_tot[k] - w0[k];
      chk($sformatf("%s c%0d busy cycles", tag, k), obs_cyc[k], ecyc[k]);
      chk($sformatf("%s c%0d writes", tag, k), obs_wr[k], ewr[k]);
      chk($sformatf("%s c%0d done pulses", tag, k), done_tot[k] - d0[k], 1);
      chk($sformatf("%s c%0d collision", tag, k), int'(coll_w[k]), ecol[k]);
      chk($sformatf("%s c%0d vram diffs", tag, k), vdiff(k), 0);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s c%0d collision held", tag, k), int'(coll_w[k]), ecol[k]);
      chk($sformatf("%s c%0d stays idle", tag, k), int'(busy_w[k]), 0);
      chk($sformatf("%s c%0d stray we", tag, k), stray_we[k], 0);
    end
    $display("draw %s x=%0d y=%0d n=%0d i=%03h p=%0d: cyc %0d/%0d wr %0d/%0d coll %0d/%0d",
             tag, xx, yy, nn, ia, pl, obs_cyc[0], obs_cyc[1], obs_wr[0], obs_wr[1],
             coll_w[0], coll_w[1]);
  endtask

  initial begin
    int w_before [2];
    logic [11:0] ria;
    reset = 1'b1; clr = 1'b1; start = 1'b0;
    x_r = '0; y_r = '0; n_r = '0; ia_r = '0; pl_r = '0;
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 128; c++)
          expv[k][r][c] = 2'b00;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    reset = 1'b0;

    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset c%0d busy", k), int'(busy_w[k]), 0);
      chk($sformatf("reset c%0d done", k), int'(done_w[k]), 0);
      chk($sformatf("reset c%0d collision", k), int'(coll_w[k]), 0);
      chk($sformatf("reset c%0d we", k), int'(we_w[k]), 0);
      chk($sformatf("reset c%0d ram_addr", k), int'(ram_addr_w[k]), 0);
      chk($sformatf("reset c%0d hpos", k), int'(hpos_w[k]), 0);
      chk($sformatf("reset c%0d vpos", k), int'(vpos_w[k]), 0);
      chk($sformatf("reset c%0d pixeli", k), int'(pixi_w[k]), 0);
    end

    // Single pixel onto blank VRAM, then the same draw again erases it
    ram[12'h300] = 8'h80;
    do_draw("single", 7'd0, 6'd0, 4'd1, 12'h300, 2'b01, 1'b0);
    chk("single cycles", obs_cyc[0], 13);
    chk("single pixel", int'(vv[0][0][0]), 1);
    chk("single collision", int'(coll_w[0]), 0);
    do_draw("erase", 7'd0, 6'd0, 4'd1, 12'h300, 2'b01, 1'b0);
    chk("erase pixel", int'(vv[0][0][0]), 0);
    chk("erase collision", int'(coll_w[0]), 1);

    // Right-edge clipping versus wrapping
    ram[12'h300] = 8'hFF;
    do_draw("edge", 7'd126, 6'd5, 4'd1, 12'h300, 2'b01, 1'b0);
    chk("edge clip writes", obs_wr[0], 2);
    chk("edge wrap writes", obs_wr[1], 8);
    chk("edge wrap col5", int'(vv[1][5][5]), 1);
    chk("edge clip col0", int'(vv[0][5][0]), 0);

    // 16x16 sprite with source address wrap and bottom clipping
    for (int i = 0; i < 32; i++) ram[(12'hFFE + i) % 4096] = 8'hFF;
    do_draw("big", 7'd0, 6'd60, 4'd0, 12'hFFE, 2'b01, 1'b0);
    chk("big clip writes", obs_wr[0], 64);
    chk("big clip cycles", obs_cyc[0], 449);
    chk("big wrap writes", obs_wr[1], 256);

    // Plane mask collision: (10,10)=10 then XOR with 11 gives 01
    ram[12'h300] = 8'h80;
    do_draw("plane10", 7'd10, 6'd10, 4'd1, 12'h300, 2'b10, 1'b0);
    do_draw("plane11", 7'd10, 6'd10, 4'd1, 12'h300, 2'b11, 1'b0);
    chk("plane11 pixel", int'(vv[0][10][10]), 1);
    chk("plane11 collision", int'(coll_w[0]), 1);

    // A start pulsed while busy is ignored
    ram[12'h500] = 8'hA5; ram[12'h501] = 8'h3C;
    do_draw("midstart", 7'd40, 6'd30, 4'd2, 12'h500, 2'b01, 1'b1);

    // plane 00 still traverses and writes back unchanged values
    do_draw("plane00", 7'd40, 6'd30, 4'd2, 12'h500, 2'b00, 1'b0);

    // Reset while the first pixel is in its VRAM read-wait cycle
    ram[12'h400] = 8'h80;
    w_before[0] = wr_tot[0];
    w_before[1] = wr_tot[1];
    @(negedge clk);
    x_r = 7'd20; y_r = 6'd20; n_r = 4'd1; ia_r = 12'h400; pl_r = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midreset c%0d we", k), int'(we_w[k]), 0);
      chk($sformatf("midreset c%0d busy", k), int'(busy_w[k]), 0);
      chk($sformatf("midreset c%0d collision", k), int'(coll_w[k]), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midreset c%0d no write", k), wr_tot[k] - w_before[k], 0);
      chk($sformatf("midreset c%0d vram", k), vdiff(k), 0);
    end
    $display("midreset: both instances idle after reset");
    do_draw("afterreset", 7'd20, 6'd20, 4'd1, 12'h400, 2'b01, 1'b0);

    // Randomized draws against the model
    for (int t = 0; t < 20; t++) begin
      ria = 12'($urandom);
      for (int i = 0; i < 32; i++) ram[(ria + 12'(i)) % 4096] = 8'($urandom);
      do_draw($sformatf("rand%0d", t), 7'($urandom), 6'($urandom), 4'($urandom),
              ria, 2'($urandom), bit'(t % 7 == 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Sequences a CHIP-8/SCHIP-style sprite draw (DXYN) into the 128x64, 2-bit-per-pixel VRAM.
- Fetches sprite rows from RAM and does a read-XOR-write per set pixel on the selected plane(s).
- Reports a collision flag for VF.
- Sits beside the CPU exec stage; the CPU hands it RAM and VRAM ports for the duration of busy.

Parameters:
- CLIP, 1, 1 = pixels past right/bottom edge dropped; 0 = pixels wrap mod 128 / mod 64.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle draw request; sampled only in IDLE
- x  in  7  origin column, latched on start
- y  in  6  origin row, latched on start
- n  in  4  rows; 1..15 = 8-wide sprite, n rows; 0 = 16x16 sprite
- i_addr  in  12  sprite base address in RAM, latched on start
- plane  in  2  plane mask XORed into each set pixel, latched on start
- busy  out  1  high from the cycle after start until DONE completes
- done  out  1  one-cycle pulse in DONE state
- collision  out  1  VF result; valid from done, held until next accepted start
- ram_addr  out  12  RAM read address
- ram_dout  in  8  RAM read data; valid 1 cycle after ram_addr
- vram_hpos  out  7  VRAM column
- vram_vpos  out  6  VRAM row
- vram_pixeli  out  2  VRAM write data
- vram_pixelo  in  2  VRAM read data; valid 1 cycle after hpos/vpos
- vram_we  out  1  VRAM write enable

Behaviour:
- Reset: state IDLE; busy, done, collision, vram_we = 0; ram_addr, hpos, vpos, pixeli = 0.
- Reset mid-draw:
  - returns to IDLE on the next edge, with vram_we low in that cycle;
  - collision is cleared;
  - the partial draw is not undone.
- Geometry:
  - n = 0 gives 16 rows of 2 bytes, 32 bytes total; byte order row r: i_addr+2r (cols 0-7), i_addr+2r+1 (cols 8-15).
  - n > 0 gives n rows of 1 byte at i_addr+r.
  - In each byte, bit 7 is the leftmost pixel.
  - All address sums wrap mod 4096.
  - Pixel coordinates are (x+col) mod 128, (y+row) mod 64.
  - With CLIP=1, any pixel whose unwrapped x+col > 127 or y+row > 63 is clipped.
- States and transitions:
  - IDLE: start -> FETCH; latch inputs; clear collision. start while busy is ignored.
  - FETCH: drive ram_addr = byte address -> FETCH_WAIT.
  - FETCH_WAIT: latch ram_dout into the shift register; bit index = 7 -> PIX.
  - PIX, bit clear or clipped: 1 cycle, advance bit.
  - PIX, bit set and not clipped: drive hpos/vpos -> PIX_WAIT.
  - PIX_WAIT: latch vram_pixelo -> PIX_WRITE.
  - PIX_WRITE:
    - vram_pixeli = latched ^ plane, vram_we = 1 for exactly this cycle;
    - if (latched & plane) != 0, set collision;
    - advance bit.
  - After bit 0: next byte -> FETCH, or -> DONE after the last byte.
  - DONE: done = 1 for one cycle -> IDLE. busy drops in the same edge.
- Cycle cost:
  - busy cycles = 2*bytes + 3*(set, unclipped bits) + 1*(other bits) + 1.
  - Example: one byte 0x80 = 2+3+7+1 = 13.
- plane = 00: the full traversal still runs; write cycles occur with pixeli = pixelo; collision stays 0.
- hpos/vpos hold their last value when not in use; vram_we is never high outside PIX_WRITE.
- ram_addr and VRAM signals are meaningful only while busy.

Test Plan:
- Blank VRAM; RAM[0x300]=0x80; start x=0 y=0 n=1 i_addr=0x300 plane=01 -> single write (0,0)=01; busy 13 cycles; done pulse; collision=0.
- Repeat the same draw -> write (0,0)=00; collision=1 held after done until the next start.
- RAM[0x300]=0xFF, x=126 y=5 n=1:
  - CLIP=1 -> writes only cols 126,127;
  - CLIP=0 -> cols 126,127,0..5 on row 5.
- n=0, i_addr=0xFFE (address wrap to 0x000..), y=60, CLIP=1, all bytes 0xFF -> 32 fetches; rows 60-63 written only; 64 writes total.
- Pixel (10,10)=10, plane=11, byte 0x80 at x=10 y=10 -> pixel 01; collision=1.
- start pulsed again while busy -> ignored.
- reset asserted during PIX_WAIT -> vram_we stays 0; next cycle idle with collision=0; a new start then runs normally.
